// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryption controller.
// Accepts a plaintext block and cipher key, runs one AES round per clock
// (10 rounds), generates each round key on the fly from the previous one,
// and holds the ciphertext on a valid/ready output until it is taken.
module aes128_iter_ctrl (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_block,
   input  logic [127:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_block,
   output logic         busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ROUND = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]   fsm_reg, fsm_next;
   logic [127:0] st_reg, st_next;
   logic [127:0] rk_reg, rk_next;
   logic [3:0]   rnd_reg, rnd_next;

   logic         accept;
   logic [7:0]   rcon;
   logic [127:0] sub_st, shifted, mixed, nk, round_st;
   logic [31:0]  w3_rot, key_sub, key_t;
   logic [31:0]  n0, n1, n2, n3;

   // GF(2^8) multiply by x modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // GF(2^8) general multiply (shift-and-add, no carries)
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] p;
      acc = 8'h00;
      p   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

   // S-box: multiplicative inverse as x^254 (0 maps to 0), then the affine map
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // Row r of the state is rotated left by r columns
   function automatic logic [127:0] aes_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   // Column mix with the fixed matrix {02 03 01 01} rotated per row
   function automatic logic [127:0] aes_mixcolumns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   // SubBytes over all 16 state bytes
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_state_sbox
         assign sub_st[127-8*gi -: 8] = sbox(st_reg[127-8*gi -: 8]);
      end
   endgenerate

   // SubWord(RotWord(w3)) for the key expansion step
   assign w3_rot = {rk_reg[23:0], rk_reg[31:24]};
   generate
      for (gi = 0; gi < 4; gi++) begin : g_key_sbox
         assign key_sub[31-8*gi -: 8] = sbox(w3_rot[31-8*gi -: 8]);
      end
   endgenerate

   // Round constant indexed by the round about to be computed
   always_comb begin
      case (rnd_reg)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   // One-step key expansion: each word chains off the previous new word
   assign key_t = key_sub ^ {rcon, 24'h000000};
   assign n0    = rk_reg[127:96] ^ key_t;
   assign n1    = rk_reg[95:64]  ^ n0;
   assign n2    = rk_reg[63:32]  ^ n1;
   assign n3    = rk_reg[31:0]   ^ n2;
   assign nk    = {n0, n1, n2, n3};

   // Final round skips MixColumns
   assign shifted  = aes_shift_rows(sub_st);
   assign mixed    = aes_mixcolumns(shifted);
   assign round_st = ((rnd_reg == 4'd10) ? shifted : mixed) ^ nk;

   assign in_ready  = !rst && ((fsm_reg == IDLE) || ((fsm_reg == DONE) && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = (fsm_reg == DONE);
   assign out_block = st_reg;
   assign busy      = (fsm_reg == ROUND);

   // Next-state: accept has priority, so a DONE handshake can restart directly
   always_comb begin
      fsm_next = fsm_reg;
      st_next  = st_reg;
      rk_next  = rk_reg;
      rnd_next = rnd_reg;
      if (accept) begin
         st_next  = in_block ^ in_key;
         rk_next  = in_key;
         rnd_next = 4'd1;
         fsm_next = ROUND;
      end else begin
         case (fsm_reg)
            ROUND: begin
               st_next = round_st;
               rk_next = nk;
               if (rnd_reg == 4'd10) fsm_next = DONE;
               else                  rnd_next = rnd_reg + 4'd1;
            end
            DONE: begin
               if (out_ready) fsm_next = IDLE;
            end
            default: ;
         endcase
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_reg <= IDLE;
         st_reg  <= '0;
         rk_reg  <= '0;
         rnd_reg <= '0;
      end else begin
         fsm_reg <= fsm_next;
         st_reg  <= st_next;
         rk_reg  <= rk_next;
         rnd_reg <= rnd_next;
      end
   end

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Testbench for aes128_iter_ctrl: FIPS-197 vectors, backpressure,
// back-to-back streaming, input perturbation and mid-operation reset,
// with random blocks checked against a byte-array AES reference model.
module tb_aes128_iter_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_block;
   logic [127:0] in_key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_block;
   logic         busy;

   int total = 0;
   int bad   = 0;

   logic [7:0] sb [256];

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

   always #5 clk = ~clk;

   aes128_iter_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_block  (in_block),
      .in_key    (in_key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_block (out_block),
      .busy      (busy)
   );

   // ---------------- reference model ----------------
   function automatic logic [7:0] m_xt(input logic [7:0] b);
      return b[7] ? (({b[6:0], 1'b0}) ^ 8'h1b) : {b[6:0], 1'b0};
   endfunction

   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] x;
      r = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ x;
         x = m_xt(x);
      end
      return r;
   endfunction

   // S-box from a brute-force inverse search plus the affine transform
   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] b;
      logic [7:0] o;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         b = inv;
         for (int i = 0; i < 8; i++)
            o[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8];
         sb[x] = o ^ 8'h63;
      end
   endtask

   // Full key schedule up front, then 10 rounds over a byte array
   function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] key);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [31:0]  w [44];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
            rc  = m_xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
               s[row+4*c] = t[row+4*((c+row)%4)];
         if (r < 10) begin
            for (int i = 0; i < 16; i++) t[i] = s[i];
            for (int c = 0; c < 4; c++)
               for (int row = 0; row < 4; row++)
                  s[row+4*c] = m_mul(8'h02, t[4*c+row]) ^ m_mul(8'h03, t[4*c+(row+1)%4]) ^
                               t[4*c+(row+2)%4] ^ t[4*c+(row+3)%4];
         end
         for (int i = 0; i < 16; i++) begin
            tmp  = w[4*r + i/4];
            s[i] = s[i] ^ tmp[31-8*(i%4) -: 8];
         end
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- drivers (no checking) ----------------
   // Presents a block and returns once it has been taken (inputs changed at posedge+1)
   task automatic accept_block(input logic [127:0] pt, input logic [127:0] key, output bit ok);
      in_block = pt;
      in_key   = key;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 60 && !ok; n++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Counts edges from the accept until out_valid is seen; also flags busy drops
   task automatic wait_out(output int cycles, output bit ok, output bit busy_err);
      cycles   = 0;
      ok       = 1'b0;
      busy_err = 1'b0;
      for (int n = 0; n < 40 && !ok; n++) begin
         @(posedge clk);
         #1;
         cycles++;
         if (out_valid) ok = 1'b1;
         else if (busy !== 1'b1) busy_err = 1'b1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_block = '0; in_key = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_held got=%b want=0", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (out_block !== 128'h0) begin bad++; $display("FAIL reset_out_block got=%h want=0", out_block); end
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_after got=%b want=1", in_ready); end
      $display("test_reset done");
   endtask

   task automatic test_vector(input string name, input logic [127:0] pt, input logic [127:0] key,
                              input logic [127:0] exp);
      bit ok, vok, berr;
      int cyc;
      out_ready = 1'b1;
      accept_block(pt, key, ok);
      total++; if (!ok) begin bad++; $display("FAIL %s_accept got=timeout want=accept", name); end
      wait_out(cyc, vok, berr);
      total++; if (!vok || cyc != 10) begin bad++; $display("FAIL %s_latency got=%0d want=10", name, cyc); end
      total++; if (berr) begin bad++; $display("FAIL %s_busy got=low want=high during rounds", name); end
      total++; if (out_block !== exp) begin bad++; $display("FAIL %s_data got=%h want=%h", name, out_block, exp); end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL %s_release got=ov%b ir%b want=ov0 ir1", name, out_valid, in_ready);
      end
      $display("vector %s: out=%h exp=%h cycles=%0d", name, out_block, exp, cyc);
   endtask

   task automatic test_backpressure();
      bit ok, vok, berr;
      int cyc, errs;
      out_ready = 1'b0;
      accept_block(B_PT, B_KEY, ok);
      wait_out(cyc, vok, berr);
      total++; if (!ok || !vok || out_block !== B_CT) begin
         bad++; $display("FAIL bp_first got=%h want=%h", out_block, B_CT);
      end
      in_block = C1_PT; in_key = C1_KEY; in_valid = 1'b1;
      errs = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_block !== B_CT || in_ready !== 1'b0 || busy !== 1'b0) errs++;
      end
      total++; if (errs != 0) begin bad++; $display("FAIL bp_hold got=%0d bad cycles want=0", errs); end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
         bad++; $display("FAIL bp_release got=ir%b ov%b want=ir1 ov1", in_ready, out_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++; if (busy !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL bp_same_edge got=busy%b ov%b want=busy1 ov0", busy, out_valid);
      end
      wait_out(cyc, vok, berr);
      total++; if (!vok || cyc != 10 || out_block !== C1_CT) begin
         bad++; $display("FAIL bp_second got=%h cyc=%0d want=%h cyc=10", out_block, cyc, C1_CT);
      end
      @(posedge clk); #1;
      $display("test_backpressure: second=%h", out_block);
   endtask

   task automatic test_back_to_back();
      logic [127:0] pts [4];
      logic [127:0] keys [4];
      logic [127:0] exps [4];
      int acc_cyc [4];
      int idx, got, acc_n;
      bit acc, hs;
      logic [127:0] ob;
      pts[0] = B_PT;  keys[0] = B_KEY;
      pts[1] = C1_PT; keys[1] = C1_KEY;
      pts[2] = rand128(); keys[2] = rand128();
      pts[3] = rand128(); keys[3] = rand128();
      for (int i = 0; i < 4; i++) exps[i] = model_encrypt(pts[i], keys[i]);
      for (int i = 0; i < 4; i++) acc_cyc[i] = 0;
      out_ready = 1'b1;
      idx = 0; got = 0; acc_n = 0;
      in_block = pts[0]; in_key = keys[0]; in_valid = 1'b1;
      for (int n = 0; n < 150 && got < 4; n++) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         hs  = out_valid && out_ready;
         ob  = out_block;
         @(posedge clk); #1;
         if (acc) begin
            if (acc_n < 4) acc_cyc[acc_n] = n;
            acc_n++;
            idx++;
            if (idx < 4) begin in_block = pts[idx]; in_key = keys[idx]; end
            else in_valid = 1'b0;
         end
         if (hs && got < 4) begin
            total++; if (ob !== exps[got]) begin bad++; $display("FAIL b2b_data%0d got=%h want=%h", got, ob, exps[got]); end
            $display("b2b block %0d: out=%h exp=%h", got, ob, exps[got]);
            got++;
         end
      end
      in_valid = 1'b0;
      total++; if (got != 4 || acc_n != 4) begin bad++; $display("FAIL b2b_count got=%0d/%0d want=4/4", got, acc_n); end
      for (int i = 1; i < 4; i++) begin
         total++; if (acc_cyc[i] - acc_cyc[i-1] != 11) begin
            bad++; $display("FAIL b2b_spacing%0d got=%0d want=11", i, acc_cyc[i] - acc_cyc[i-1]);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_perturb();
      bit ok, vok, berr;
      int cyc;
      logic [127:0] pt, key, exp;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         pt = rand128(); key = rand128();
         exp = model_encrypt(pt, key);
         accept_block(pt, key, ok);
         cyc = 0; vok = 1'b0;
         for (int n = 0; n < 40 && !vok; n++) begin
            @(posedge clk); #1;
            cyc++;
            if (out_valid) vok = 1'b1;
            else begin
               in_block = rand128();
               in_key   = rand128();
               in_valid = (cyc <= 8) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
         end
         in_valid = 1'b0;
         total++; if (!ok || !vok || cyc != 10 || out_block !== exp) begin
            bad++; $display("FAIL perturb%0d got=%h cyc=%0d want=%h cyc=10", k, out_block, cyc, exp);
         end
         $display("perturb %0d: out=%h exp=%h", k, out_block, exp);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      bit ok, vok, berr;
      int cyc;
      out_ready = 1'b1;
      accept_block(C1_PT, C1_KEY, ok);
      repeat (4) @(posedge clk);
      #1; rst = 1'b1;
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rmid_in_ready_rst got=%b want=0", in_ready); end
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      total++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_block !== 128'h0) begin
         bad++; $display("FAIL rmid_round got=ov%b busy%b ir%b ob=%h want=ov0 busy0 ir1 ob=0",
                         out_valid, busy, in_ready, out_block);
      end
      out_ready = 1'b0;
      accept_block(B_PT, B_KEY, ok);
      wait_out(cyc, vok, berr);
      total++; if (!vok || out_block !== B_CT) begin bad++; $display("FAIL rdone_pre got=%h want=%h", out_block, B_CT); end
      rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      total++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_block !== 128'h0) begin
         bad++; $display("FAIL rmid_done got=ov%b busy%b ir%b ob=%h want=ov0 busy0 ir1 ob=0",
                         out_valid, busy, in_ready, out_block);
      end
      test_vector("reset_recover", C1_PT, C1_KEY, C1_CT);
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_vector("fips_c1", C1_PT, C1_KEY, C1_CT);
      test_vector("fips_b", B_PT, B_KEY, B_CT);
      test_backpressure();
      test_back_to_back();
      test_perturb();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
